// File: rtl/xadc_drp_pkg.sv
// Shared definitions for the XADC DRP read initiator: FSM state encoding,
// DRP address map constants and sample/average widths.
package xadc_drp_pkg;

  // ST_AVG is only entered when the averaging build (AVG_EN) is selected.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_STORE = 3'd3,
    ST_AVG   = 3'd4
  } drp_state_e;

  // Status register of VAUX[n] lives at 0x10 + n.
  localparam logic [6:0] XADC_AUX_BASE_ADDR = 7'h10;

  // Result width held per slot (DO[15:4]).
  localparam int SAMPLE_W = 12;

  // XADC channel code of VAUX[0].
  localparam int CH_CODE_OFFSET = 16;

  // Moving-average history depth and accumulator width (4 x 12 bit).
  localparam int AVG_DEPTH = 4;
  localparam int AVG_SUM_W = 14;

endpackage

// File: rtl/sample_averager.sv
// Per-slot 4-deep sample history with a truncating mean of the stored
// samples. History starts at zero, so the first few outputs ramp up.
module sample_averager
  import xadc_drp_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic [SAMPLE_W-1:0] sample_in,
  output logic [SAMPLE_W-1:0] avg_out
);

  logic [AVG_DEPTH-1:0][SAMPLE_W-1:0] hist_q;
  logic [AVG_DEPTH-1:0][SAMPLE_W-1:0] hist_d;
  logic [AVG_SUM_W-1:0]               sum;

  // Shift the new sample in at position 0, oldest falls off the end.
  always_comb begin
    hist_d = hist_q;
    if (push) begin
      hist_d[0] = sample_in;
      for (int i = 1; i < AVG_DEPTH; i++) begin
        hist_d[i] = hist_q[i-1];
      end
    end
  end

  // History register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

  // Sum of the history; divide by 4 by dropping the two LSBs (no rounding).
  always_comb begin
    sum = '0;
    for (int i = 0; i < AVG_DEPTH; i++) begin
      sum = sum + AVG_SUM_W'(hist_q[i]);
    end
    avg_out = SAMPLE_W'(sum >> 2);
  end

endmodule

// File: rtl/xadc_drp_reader.sv
// DRP read initiator for the XADC auxiliary channels. Each accepted EOC
// triggers one DEN pulse reading the channel's status register, waits for
// DRDY under a timeout and stores DO[15:4] into the channel's slot.
// Optional build macro AVG_EN: each slot outputs the mean of its last four
// samples and VALID is delayed by one extra cycle.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | ready; EOC on a serviced channel latches slot and address
// ST_REQ   | DEN high for this single cycle, timeout counter cleared
// ST_WAIT  | waiting for DRDY; capture on DRDY, give up at DRDY_TIMEOUT
// ST_STORE | slot just updated; VALID pulses here in the raw build
// ST_AVG   | averaged build only: VALID pulses here instead of ST_STORE
module xadc_drp_reader
  import xadc_drp_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int BASE_AUX     = 0,
  parameter int DRDY_TIMEOUT = 15
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       EOC,
  input  logic [4:0]                 CHANNEL,
  input  logic                       DRDY,
  input  logic [15:0]                DO,
  output logic [6:0]                 DADDR,
  output logic                       DEN,
  output logic                       DWE,
  output logic [SAMPLE_W*NUM_CH-1:0] SAMPLES,
  output logic                       VALID,
  output logic [2:0]                 VALID_CH,
  output logic                       TIMEOUT_ERR,
  output logic                       OVERRUN
);

  localparam int CH_LO = CH_CODE_OFFSET + BASE_AUX;

  drp_state_e state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [6:0] daddr_q, daddr_d;
  logic [7:0] cnt_q, cnt_d;
  logic       to_err_q, to_err_d;
  logic       overrun_q, overrun_d;

  logic [5:0] ch_rel;
  logic       ch_hit;
  logic       cap_we;
  logic       den;
  logic       valid;
  logic       unused_do_lsb;

  // The low nibble of DO carries no conversion data.
  assign unused_do_lsb = ^DO[3:0];

  // Slot decode of the incoming channel code.
  always_comb begin
    ch_rel = {1'b0, CHANNEL} - 6'(CH_LO);
    ch_hit = ({1'b0, CHANNEL} >= 6'(CH_LO)) && (ch_rel < 6'(NUM_CH));
  end

  // Next-state and output decode of the read sequencer.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    daddr_d   = daddr_q;
    cnt_d     = cnt_q;
    to_err_d  = to_err_q;
    overrun_d = overrun_q;
    cap_we    = 1'b0;
    den       = 1'b0;
    valid     = 1'b0;

    // EOCs are never queued; any arriving while busy is only flagged.
    if (EOC && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (EOC && ch_hit) begin
          idx_d   = 3'(ch_rel);
          daddr_d = XADC_AUX_BASE_ADDR + 7'(BASE_AUX) + 7'(ch_rel);
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        den     = 1'b1;
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // DRDY is checked first so it wins over the final timeout count.
        if (DRDY) begin
          cap_we  = 1'b1;
          state_d = ST_STORE;
        end else if ((cnt_q + 8'd1) == 8'(DRDY_TIMEOUT)) begin
          to_err_d = 1'b1;
          cnt_d    = '0;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_STORE: begin
`ifdef AVG_EN
        state_d = ST_AVG;
`else
        valid   = 1'b1;
        state_d = ST_IDLE;
`endif
      end
`ifdef AVG_EN
      ST_AVG: begin
        valid   = 1'b1;
        state_d = ST_IDLE;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer registers and sticky error flags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      daddr_q   <= '0;
      cnt_q     <= '0;
      to_err_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      daddr_q   <= daddr_d;
      cnt_q     <= cnt_d;
      to_err_q  <= to_err_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef AVG_EN
  // One averager per slot; the raw capture is pushed on the DRDY edge.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_avg
    sample_averager u_avg (
      .clk       (CLK),
      .rst       (RST),
      .push      (cap_we && (idx_q == 3'(k))),
      .sample_in (DO[15:4]),
      .avg_out   (SAMPLES[k*SAMPLE_W +: SAMPLE_W])
    );
  end
`else
  logic [NUM_CH-1:0][SAMPLE_W-1:0] samples_q, samples_d;

  // The slot is written on the DRDY edge so it is already updated when
  // VALID pulses in the following cycle.
  always_comb begin
    samples_d = samples_q;
    for (int k = 0; k < NUM_CH; k++) begin
      if (cap_we && (idx_q == 3'(k))) begin
        samples_d[k] = DO[15:4];
      end
    end
  end

  // Per-slot result registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      samples_q <= '0;
    end else begin
      samples_q <= samples_d;
    end
  end

  assign SAMPLES = samples_q;
`endif

  assign DADDR       = daddr_q;
  assign DEN         = den;
  assign DWE         = 1'b0;
  assign VALID       = valid;
  assign VALID_CH    = idx_q;
  assign TIMEOUT_ERR = to_err_q;
  assign OVERRUN     = overrun_q;

endmodule
